// File: rtl/spm_mesh_feeder_pkg.sv
// spm_types: shared state enum for the mesh feeder.
// Imported by the feeder top.
package spm_types;

    typedef enum logic [1:0] {
        sfd_idle,
        sfd_feed,
        sfd_drain,
        sfd_done
    } spm_feed_fsm_t;

endpackage

// File: rtl/spm_mesh_feeder_if.sv
// Feeder bus: FIFO head/pop, packet launch, skewed mesh outputs.
// Lane i data sits at mesh_data MSB-first; mesh_valid[i] flags lane i.
interface spm_mesh_feeder_if #(
    parameter int SRAM_WORD_SIZE = 32,
    parameter int BANK_SIZE      = 512,
    parameter int LANE_WIDTH     = 8
);
    localparam int NUM_LANES = SRAM_WORD_SIZE / LANE_WIDTH;
    localparam int CW        = $clog2(BANK_SIZE);

    logic                            start;
    logic [CW-1:0]                   num_words;
    logic [SRAM_WORD_SIZE-1:0]       fifo_rdata;
    logic                            fifo_empty;
    logic                            dequeue;
    logic                            mesh_ready;
    logic [NUM_LANES*LANE_WIDTH-1:0] mesh_data;
    logic [NUM_LANES-1:0]            mesh_valid;
    logic                            feed_done;

    modport master (
        output start, num_words, fifo_rdata, fifo_empty, mesh_ready,
        input  dequeue, mesh_data, mesh_valid, feed_done
    );

    modport slave (
        input  start, num_words, fifo_rdata, fifo_empty, mesh_ready,
        output dequeue, mesh_data, mesh_valid, feed_done
    );

endinterface

// File: rtl/spm_mesh_feeder_skew.sv
// spm_skew_line: enable-gated data+valid delay line.
// Output appears DEPTH+1 enabled edges after input.
module spm_skew_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic             vin,
    output logic [WIDTH-1:0] dout,
    output logic             vout
);

    logic [WIDTH-1:0] d_q [DEPTH+1];
    logic [DEPTH:0]   v_q;

    // Shift operands one stage per enabled edge, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= DEPTH; k++) d_q[k] <= '0;
            v_q <= '0;
        end else if (en) begin
            d_q[0] <= din;
            v_q[0] <= vin;
            for (int k = 1; k <= DEPTH; k++) begin
                d_q[k] <= d_q[k-1];
                v_q[k] <= v_q[k-1];
            end
        end
    end

    assign dout = d_q[DEPTH];
    assign vout = v_q[DEPTH];

endmodule

// File: rtl/spm_mesh_feeder.sv
// spm_mesh_feeder: pops a packet from the mesh FIFO and feeds the mesh.
// Define SPM_FEEDER_SKEW_EN for diagonal lane skew plus drain phase.
module spm_mesh_feeder
    import spm_types::*;
#(
    parameter int SRAM_WORD_SIZE = 32,
    parameter int BANK_SIZE      = 512,
    parameter int LANE_WIDTH     = 8
) (
    input logic               clk,
    input logic               rst,
    spm_mesh_feeder_if.slave  bus
);

    localparam int NUM_LANES = SRAM_WORD_SIZE / LANE_WIDTH;
    localparam int CW        = $clog2(BANK_SIZE);
    localparam int MW        = NUM_LANES * LANE_WIDTH;
`ifdef SPM_FEEDER_SKEW_EN
    localparam int SKEW      = 1;
`else
    localparam int SKEW      = 0;
`endif
    localparam int DRAIN     = SKEW * (NUM_LANES - 1);
    localparam int DW        = (DRAIN > 1) ? $clog2(DRAIN) : 1;

    spm_feed_fsm_t state;
    logic [CW-1:0] count;
    logic [DW-1:0] drain_cnt;
    logic          deq;
    logic          adv;

    assign adv = bus.mesh_ready;
    assign deq = !rst && (state == sfd_feed) && !bus.fifo_empty
               && bus.mesh_ready && (count != '0);
    assign bus.dequeue = deq;

    // Packet sequencing: count words out, wait for skew to drain, pulse done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= sfd_idle;
            count         <= '0;
            drain_cnt     <= '0;
            bus.feed_done <= 1'b0;
        end else begin
            bus.feed_done <= (state == sfd_done);
            unique case (state)
                sfd_idle: begin
                    if (bus.start) begin
                        count     <= bus.num_words;
                        drain_cnt <= '0;
                        state     <= (bus.num_words == '0) ? sfd_done
                                                           : sfd_feed;
                    end
                end
                sfd_feed: begin
                    if (deq) begin
                        count <= count - 1'b1;
                        if (count == CW'(1))
                            state <= (DRAIN == 0) ? sfd_done : sfd_drain;
                    end
                end
                sfd_drain: begin
                    if (adv) begin
                        if (drain_cnt == DW'(DRAIN - 1))
                            state <= sfd_done;
                        else
                            drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                sfd_done: state <= sfd_idle;
                default:  state <= sfd_idle;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [LANE_WIDTH-1:0] op;

        assign op = deq
            ? bus.fifo_rdata[SRAM_WORD_SIZE-1-i*LANE_WIDTH -: LANE_WIDTH]
            : '0;

        spm_skew_line #(
            .WIDTH (LANE_WIDTH),
            .DEPTH (SKEW * i)
        ) u_line (
            .clk  (clk),
            .rst  (rst),
            .en   (adv),
            .din  (op),
            .vin  (deq),
            .dout (bus.mesh_data[MW-1-i*LANE_WIDTH -: LANE_WIDTH]),
            .vout (bus.mesh_valid[i])
        );
    end

endmodule
